// File: rtl/seg_display_if.sv
// Core-side bundle for the 7-segment scanner: display data and controls in,
// anode/cathode/dp pin drives and the frame boundary pulse out.
interface seg_display_if #(
    parameter int DIGITS      = 4,
    parameter int BRIGHT_BITS = 4
);
    logic                   enable;
    logic [4*DIGITS-1:0]    numbers;
    logic [DIGITS-1:0]      dots;
    logic [DIGITS-1:0]      blink;
    logic                   lz_blank;
    logic [BRIGHT_BITS-1:0] brightness;
    logic [DIGITS-1:0]      anodes;
    logic [6:0]             catodes;
    logic                   dp;
    logic                   frame_done;

    modport master (
        output enable, numbers, dots, blink, lz_blank, brightness,
        input  anodes, catodes, dp, frame_done
    );

    modport slave (
        input  enable, numbers, dots, blink, lz_blank, brightness,
        output anodes, catodes, dp, frame_done
    );
endinterface

// File: rtl/seg_display_scan.sv
// Time-multiplexed common-anode 7-segment scanner with per-digit decimal
// points and blink, leading-zero blanking, PWM dimming and frame-latched data.
module seg_display_scan #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_CYCLES = 25000,
    parameter int BLINK_CYCLES   = 25000000,
    parameter int BRIGHT_BITS    = 4
) (
    input logic         clk,
    input logic         rst,
    seg_display_if.slave bus
);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int REF_W = $clog2(REFRESH_CYCLES);
    localparam int BLK_W = $clog2(BLINK_CYCLES);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_HALF = BLK_W'(BLINK_CYCLES / 2);

    logic [REF_W-1:0]          refresh_cnt;
    logic [BLK_W-1:0]          blink_cnt;
    logic [BRIGHT_BITS-1:0]    pwm_cnt;
    logic [IDX_W-1:0]          idx;

    logic [DIGITS-1:0][3:0]    sh_nib;
    logic [DIGITS-1:0]         sh_dots;
    logic [DIGITS-1:0]         sh_blink;
    logic                      sh_lz;

    logic [DIGITS-1:0]         anodes_q;
    logic [6:0]                catodes_q;
    logic                      dp_q;
    logic                      frame_done_q;

    logic                      tick;
    logic                      frame_tick;
    logic                      blink_off;
    logic                      pwm_on;
    logic                      zeros_above;
    logic [DIGITS-1:0]         blank;
    logic [DIGITS-1:0]         anodes_next;
    logic [6:0]                catodes_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    assign tick       = (refresh_cnt == REF_LAST);
    assign frame_tick = tick && (idx == IDX_LAST);
    assign blink_off  = (blink_cnt < BLK_HALF);
    assign pwm_on     = (pwm_cnt <= bus.brightness);

    // A digit is blank when it and every more-significant nibble are zero;
    // digit 0 always shows so a zero value still reads "0".
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        zeros_above = 1'b1;
        blank       = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zeros_above = zeros_above & (sh_nib[i] == 4'h0);
            if (i != 0) blank[i] = sh_lz & zeros_above;
        end
    end

    always_comb begin
        anodes_next  = '1;
        catodes_next = blank[idx] ? 7'b1111111 : seg_decode(sh_nib[idx]);
        if (bus.enable && pwm_on && !(sh_blink[idx] && blink_off))
            anodes_next[idx] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt  <= '0;
            blink_cnt    <= '0;
            pwm_cnt      <= '0;
            idx          <= '0;
            sh_nib       <= '0;
            sh_dots      <= '0;
            sh_blink     <= '0;
            sh_lz        <= 1'b0;
            anodes_q     <= '1;
            catodes_q    <= 7'b1111111;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            refresh_cnt <= tick ? '0 : refresh_cnt + 1'b1;
            blink_cnt   <= (blink_cnt == BLK_LAST) ? '0 : blink_cnt + 1'b1;
            pwm_cnt     <= pwm_cnt + 1'b1;
            if (tick)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

            // Inputs are only taken at the frame boundary, so a frame never tears.
            if (frame_tick) begin
                sh_nib   <= bus.numbers;
                sh_dots  <= bus.dots;
                sh_blink <= bus.blink;
                sh_lz    <= bus.lz_blank;
            end

            frame_done_q <= frame_tick;
            anodes_q     <= anodes_next;
            catodes_q    <= catodes_next;
            dp_q         <= ~sh_dots[idx];
        end
    end

    assign bus.anodes     = anodes_q;
    assign bus.catodes    = catodes_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with DIGITS=4, REFRESH_CYCLES=4,
// BLINK_CYCLES=16, BRIGHT_BITS=2; every frame is checked cycle by cycle.
module tb_seg_display_scan;
    localparam int DIGITS  = 4;
    localparam int REFRESH = 4;
    localparam int BLINK   = 16;
    localparam int BB      = 2;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
    localparam logic [6:0] SA = 7'b0001000, SB = 7'b1100000, SC = 7'b0110001;
    localparam logic [6:0] SD = 7'b1000010, SX = 7'b1111111;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg_display_if #(.DIGITS(DIGITS), .BRIGHT_BITS(BB)) bus ();

    seg_display_scan #(
        .DIGITS(DIGITS), .REFRESH_CYCLES(REFRESH),
        .BLINK_CYCLES(BLINK), .BRIGHT_BITS(BB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Steps 16 negedges starting right after a frame boundary (or reset release).
    // Cycle j shows digit j/4 at PWM count j%4; frame_done is due on cycle 15.
    task automatic check_frame(input string name,
                               input logic [6:0] c0, input logic [6:0] c1,
                               input logic [6:0] c2, input logic [6:0] c3,
                               input logic [3:0] exp_dp, input logic [3:0] dig_lit,
                               input logic [3:0] pwm_lit,
                               input bit chg, input logic [15:0] chg_num);
        logic [6:0] cat [4];
        cat = '{c0, c1, c2, c3};
        for (int j = 0; j < 16; j++) begin
            int d;
            int p;
            logic [3:0] exp_an;
            logic       exp_fd;
            @(negedge clk);
            if (chg && j == 8) bus.numbers = chg_num;
            d      = j / 4;
            p      = j % 4;
            exp_an = (dig_lit[d] && pwm_lit[p]) ? ~(4'b0001 << d) : 4'b1111;
            exp_fd = (j == 15);
            checks++;
            if (bus.anodes !== exp_an) begin
                errors++;
                $display("FAIL %s cyc%0d anodes got %b expected %b", name, j, bus.anodes, exp_an);
            end
            checks++;
            if (bus.catodes !== cat[d]) begin
                errors++;
                $display("FAIL %s cyc%0d catodes got %b expected %b", name, j, bus.catodes, cat[d]);
            end
            checks++;
            if (bus.dp !== exp_dp[d]) begin
                errors++;
                $display("FAIL %s cyc%0d dp got %b expected %b", name, j, bus.dp, exp_dp[d]);
            end
            checks++;
            if (bus.frame_done !== exp_fd) begin
                errors++;
                $display("FAIL %s cyc%0d frame_done got %b expected %b", name, j, bus.frame_done, exp_fd);
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (bus.anodes !== 4'b1111) begin
            errors++;
            $display("FAIL %s anodes got %b expected 1111", name, bus.anodes);
        end
        checks++;
        if (bus.catodes !== 7'b1111111) begin
            errors++;
            $display("FAIL %s catodes got %b expected 1111111", name, bus.catodes);
        end
        checks++;
        if (bus.dp !== 1'b1) begin
            errors++;
            $display("FAIL %s dp got %b expected 1", name, bus.dp);
        end
        checks++;
        if (bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s frame_done got %b expected 0", name, bus.frame_done);
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.enable     = 1'b1;
        bus.brightness = 2'd3;
        bus.numbers    = 16'h1234;
        bus.dots       = 4'b0000;
        bus.blink      = 4'b0000;
        bus.lz_blank   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        // First frame after reset shows the zeroed shadow registers.
        check_frame("reset_frame", S0, S0, S0, S0, 4'hF, 4'hF, 4'hF, 1'b0, 16'h0);
    endtask

    task automatic test_scan();
        check_frame("scan", S4, S3, S2, S1, 4'hF, 4'hF, 4'hF, 1'b0, 16'h0);
    endtask

    task automatic test_tear_free();
        check_frame("tear_old", S4, S3, S2, S1, 4'hF, 4'hF, 4'hF, 1'b1, 16'hABCD);
        check_frame("tear_new", SD, SC, SB, SA, 4'hF, 4'hF, 4'hF, 1'b0, 16'h0);
    endtask

    task automatic test_lz_blank();
        bus.numbers  = 16'h0050;
        bus.lz_blank = 1'b1;
        bus.dots     = 4'b0100;
        check_frame("lz_pre", SD, SC, SB, SA, 4'hF, 4'hF, 4'hF, 1'b0, 16'h0);
        check_frame("lz_0050", S0, S5, SX, SX, 4'b1011, 4'hF, 4'hF, 1'b0, 16'h0);
        bus.numbers = 16'h0000;
        bus.dots    = 4'b0000;
        check_frame("lz_pre2", S0, S5, SX, SX, 4'b1011, 4'hF, 4'hF, 1'b0, 16'h0);
        check_frame("lz_zero", S0, SX, SX, SX, 4'hF, 4'hF, 4'hF, 1'b0, 16'h0);
    endtask

    // Blink counter runs in step with the frame: digits 0/1 fall in the
    // off-phase (count 0..7), digits 2/3 in the on-phase (count 8..15).
    task automatic test_blink();
        bus.numbers  = 16'h1234;
        bus.lz_blank = 1'b0;
        bus.blink    = 4'b0001;
        check_frame("blink_pre", S0, SX, SX, SX, 4'hF, 4'hF, 4'hF, 1'b0, 16'h0);
        check_frame("blink_d0", S4, S3, S2, S1, 4'hF, 4'b1110, 4'hF, 1'b0, 16'h0);
        bus.blink = 4'b0110;
        check_frame("blink_pre2", S4, S3, S2, S1, 4'hF, 4'b1110, 4'hF, 1'b0, 16'h0);
        check_frame("blink_d12", S4, S3, S2, S1, 4'hF, 4'b1101, 4'hF, 1'b0, 16'h0);
        bus.blink = 4'b0000;
        check_frame("blink_pre3", S4, S3, S2, S1, 4'hF, 4'b1101, 4'hF, 1'b0, 16'h0);
    endtask

    task automatic test_brightness();
        bus.brightness = 2'd0;
        check_frame("bright0", S4, S3, S2, S1, 4'hF, 4'hF, 4'b0001, 1'b0, 16'h0);
        bus.brightness = 2'd1;
        check_frame("bright1", S4, S3, S2, S1, 4'hF, 4'hF, 4'b0011, 1'b0, 16'h0);
        bus.brightness = 2'd3;
        check_frame("bright3", S4, S3, S2, S1, 4'hF, 4'hF, 4'hF, 1'b0, 16'h0);
    endtask

    task automatic test_enable();
        bus.enable = 1'b0;
        check_frame("disabled", S4, S3, S2, S1, 4'hF, 4'h0, 4'hF, 1'b0, 16'h0);
        bus.enable = 1'b1;
        check_frame("reenabled", S4, S3, S2, S1, 4'hF, 4'hF, 4'hF, 1'b0, 16'h0);
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst = 1'b0;
        check_frame("post_reset", S0, S0, S0, S0, 4'hF, 4'hF, 4'hF, 1'b0, 16'h0);
        check_frame("post_reset2", S4, S3, S2, S1, 4'hF, 4'hF, 4'hF, 1'b0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_lz_blank();
        test_blink();
        test_brightness();
        test_enable();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
